// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit MIPS register file, two async read ports, one sync write port, $0 hardwired to zero
// Ports: clk (rising edge), rst_n (async active-low clear of all registers),
//        we/wa/wd (write-back write port, wa from the RegDst mux),
//        ra1/rd1 (rs read), ra2/rd2 (rt read), both combinational.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding to both read ports.
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;
    logic              byp1;
    logic              byp2;

    assign wr_en = we && (wa != '0);

    // Flops rather than RAM so the whole array clears asynchronously; entry 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = rst_n && wr_en && (ra1 == wa);
    assign byp2 = rst_n && wr_en && (ra2 == wa);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : byp1 ? wd : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : byp2 ? wd : regs[ra2];
    end
endmodule
